// File: rtl/cpu_top.sv
// Minimal strobe-sequenced CPU core: PC, constant 16-entry instruction ROM, IR and
// an 8 x 8-bit register file. fetch loads IR; start_move/start_movi execute it.
module cpu_top #(
    parameter int DATA_W     = 8,
    parameter int NREG       = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_move,
    input  logic                   start_movi,
    input  logic                   fetch,
    output logic [PC_W-1:0]        pc,
    output logic [15:0]            ir,
    output logic                   done,
    output logic                   err,
    output logic [NREG*DATA_W-1:0] regs_flat
);

    localparam logic [3:0] OP_MOVE = 4'h1;
    localparam logic [3:0] OP_MOVI = 4'h2;

    logic [DATA_W-1:0] regs [NREG];
    logic [15:0]       rom_data;
    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [7:0]        imm;

    always_comb begin
        rom_data = 16'h0000;
        case (pc)
            PC_W'(0): rom_data = 16'h1250;
            PC_W'(1): rom_data = 16'h23A7;
            PC_W'(2): rom_data = 16'h1132;
            default:  rom_data = 16'h0000;
        endcase
    end

    assign opcode = ir[15:12];
    assign rd     = ir[10:8];
    assign rs     = ir[6:4];
    assign imm    = ir[7:0];

    // fetch beats start_move beats start_movi; only the winner acts
    always_ff @(posedge clk) begin
        if (reset) begin
            pc   <= '0;
            ir   <= 16'h0000;
            done <= 1'b0;
            err  <= 1'b0;
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= DATA_W'(k);
            end
        end else begin
            done <= 1'b0;
            if (fetch) begin
                ir <= rom_data;
                pc <= pc + PC_W'(1);
            end else if (start_move) begin
                if (opcode == OP_MOVE) begin
                    regs[rd] <= regs[rs];
                    done     <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else if (start_movi) begin
                if (opcode == OP_MOVI) begin
                    regs[rd] <= imm;
                    done     <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NREG; k++) begin
            regs_flat[k*DATA_W +: DATA_W] = regs[k];
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: directed vector table, a wrap/NOP sequence,
// then randomized strobes compared against a behavioural model.
module tb_cpu_top;

    logic        clk = 1'b0;
    logic        reset, start_move, start_movi, fetch;
    logic [3:0]  pc;
    logic [15:0] ir;
    logic        done, err;
    logic [63:0] regs_flat;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_top dut (
        .clk        (clk),
        .reset      (reset),
        .start_move (start_move),
        .start_movi (start_movi),
        .fetch      (fetch),
        .pc         (pc),
        .ir         (ir),
        .done       (done),
        .err        (err),
        .regs_flat  (regs_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, f, mv, mi;
        logic [3:0]  pc;
        logic [15:0] ir;
        logic        done, err;
        logic [63:0] regs;
    } vec_t;

    vec_t tbl [13];

    // behavioural model state
    logic [15:0] rom [16];
    int          m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_regs [8];
    logic        m_done, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic mv, input logic mi);
        reset = r; fetch = f; start_move = mv; start_movi = mi;
        @(posedge clk);
        #1;
        reset = 1'b0; fetch = 1'b0; start_move = 1'b0; start_movi = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_pc, input logic [15:0] e_ir,
                           input logic e_done, input logic e_err, input logic [63:0] e_regs);
        chk({tag, ".pc"},   64'(pc),   64'(e_pc));
        chk({tag, ".ir"},   64'(ir),   64'(e_ir));
        chk({tag, ".done"}, 64'(done), 64'(e_done));
        chk({tag, ".err"},  64'(err),  64'(e_err));
        chk({tag, ".regs"}, regs_flat, e_regs);
    endtask

    task automatic model_step(input logic r, input logic f, input logic mv, input logic mi);
        int rd_i, rs_i;
        rd_i = int'(m_ir[10:8]);
        rs_i = int'(m_ir[6:4]);
        if (r) begin
            m_pc = 0; m_ir = 16'h0; m_done = 0; m_err = 0;
            for (int k = 0; k < 8; k++) m_regs[k] = 8'(k);
        end else begin
            m_done = 0;
            if (f) begin
                m_ir = rom[m_pc];
                m_pc = (m_pc + 1) % 16;
            end else if (mv) begin
                if (m_ir[15:12] == 4'd1) begin
                    m_regs[rd_i] = m_regs[rs_i];
                    m_done = 1;
                end else m_err = 1;
            end else if (mi) begin
                if (m_ir[15:12] == 4'd2) begin
                    m_regs[rd_i] = m_ir[7:0];
                    m_done = 1;
                end else m_err = 1;
            end
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = m_regs[k];
        return v;
    endfunction

    initial begin
        reset = 1'b1; fetch = 1'b0; start_move = 1'b0; start_movi = 1'b0;
        for (int k = 0; k < 16; k++) rom[k] = 16'h0000;
        rom[0] = 16'h1250; rom[1] = 16'h23A7; rom[2] = 16'h1132;

        //          rst   f     mv    mi    pc    ir        done  err   regs
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 64'h0706050403020100};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'h1250, 1'b0, 1'b0, 64'h0706050403020100};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h1250, 1'b1, 1'b0, 64'h0706050403050100};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 16'h1250, 1'b0, 1'b0, 64'h0706050403050100};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h23A7, 1'b0, 1'b0, 64'h0706050403050100};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h23A7, 1'b1, 1'b0, 64'h07060504A7050100};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h23A7, 1'b0, 1'b0, 64'h07060504A7050100};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h23A7, 1'b0, 1'b1, 64'h07060504A7050100};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h23A7, 1'b0, 1'b1, 64'h07060504A7050100};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h1132, 1'b0, 1'b1, 64'h07060504A7050100};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'h1132, 1'b1, 1'b1, 64'h07060504A705A700};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h1132, 1'b1, 1'b1, 64'h07060504A705A700};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 64'h0706050403020100};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].f, tbl[i].mv, tbl[i].mi);
            chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ir, tbl[i].done, tbl[i].err, tbl[i].regs);
        end

        // fetch held high for 16 edges wraps the PC; ROM[15] is a NOP
        reset = 1'b0; fetch = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        fetch = 1'b0;
        chk_all("wrap", 4'd0, 16'h0000, 1'b0, 1'b0, 64'h0706050403020100);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("nop_movi", 4'd0, 16'h0000, 1'b0, 1'b1, 64'h0706050403020100);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("refetch", 4'd2, 16'h23A7, 1'b0, 1'b1, 64'h0706050403020100);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk_all("rst_vs_movi", 4'd0, 16'h0000, 1'b0, 1'b0, 64'h0706050403020100);

        // randomized strobes against the model
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic r, f, mv, mi;
            r  = ($urandom_range(0, 49) == 0);
            f  = ($urandom_range(0, 2) == 0);
            mv = $urandom_range(0, 1) == 1;
            mi = $urandom_range(0, 1) == 1;
            cycle(r, f, mv, mi);
            model_step(r, f, mv, mi);
            chk_all($sformatf("rnd%0d", i), 4'(m_pc), m_ir, m_done, m_err, model_flat());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
